// File: rtl/mosquito_pkg.sv
// rtl/mosquito_pkg.sv - shared constants, state type and hitbox helper for the mosquito game
package mosquito_pkg;

  localparam int COORD_W    = 10;
  localparam int IDX_W      = 3;
  localparam int N_MOSQ_DEF = 2;
  localparam int MOSQ_W_DEF = 32;
  localparam int MOSQ_H_DEF = 32;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;

  // One extra bit so that position + sprite size can never wrap
  localparam int SPAN_W = COORD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_KILL,
    ST_COOLDOWN
  } hit_state_e;

  // True when pt lies in [lo, lo + size - 1], evaluated in SPAN_W bits
  function automatic logic in_span(input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] pt,
                                   input logic [SPAN_W-1:0]  size);
    logic [SPAN_W-1:0] hi;
    hi = {1'b0, lo} + size;
    return ({1'b0, pt} >= {1'b0, lo}) && ({1'b0, pt} < hi);
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - two-digit BCD score counter saturating at 99
module bcd_score_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  output logic [7:0] score_bcd_o
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       at_max;

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  // Next score: ones wrap 9->0 with carry into tens, hold once 99 is reached
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (inc_i && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign score_bcd_o = {tens_q, ones_q};

endmodule

// File: rtl/mosquito_hit_detector.sv
// rtl/mosquito_hit_detector.sv - scans mosquitoes against the aim point on each shot and requests one kill
module mosquito_hit_detector
  import mosquito_pkg::*;
#(
  parameter int N_MOSQ          = N_MOSQ_DEF,
  parameter int MOSQ_W          = MOSQ_W_DEF,
  parameter int MOSQ_H          = MOSQ_H_DEF,
  parameter int COOLDOWN_CYCLES = 12_500_000
) (
  input  logic                        clk25,
  input  logic                        reset,
  input  logic                        fire,
  input  logic [COORD_W-1:0]          aim_x,
  input  logic [COORD_W-1:0]          aim_y,
  input  logic [COORD_W*N_MOSQ-1:0]   mosq_x,
  input  logic [COORD_W*N_MOSQ-1:0]   mosq_y,
  input  logic [N_MOSQ-1:0]           mosq_alive,
  output logic                        kill_valid,
  output logic [IDX_W-1:0]            kill_idx,
  input  logic                        kill_ready,
  output logic                        shot_miss,
  output logic                        busy,
  output logic [7:0]                  score_bcd
);

  localparam int                CNT_W    = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_MOSQ - 1);
  localparam logic [SPAN_W-1:0] HIT_W    = SPAN_W'(MOSQ_W);
  localparam logic [SPAN_W-1:0] HIT_H    = SPAN_W'(MOSQ_H);

  hit_state_e         state_q, state_d;
  logic               fire_prev_q;
  logic [COORD_W-1:0] aim_x_q, aim_x_d;
  logic [COORD_W-1:0] aim_y_q, aim_y_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               kill_valid_q, kill_valid_d;
  logic [IDX_W-1:0]   kill_idx_q, kill_idx_d;
  logic               shot_miss_q, shot_miss_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fire_edge;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               cur_alive;
  logic               cur_hit;
  logic               score_inc;

  assign fire_edge = fire & ~fire_prev_q;

  // Select the live position and alive flag of the mosquito under evaluation
  always_comb begin
    cur_x     = '0;
    cur_y     = '0;
    cur_alive = 1'b0;
    for (int i = 0; i < N_MOSQ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_x     = mosq_x[i*COORD_W +: COORD_W];
        cur_y     = mosq_y[i*COORD_W +: COORD_W];
        cur_alive = mosq_alive[i];
      end
    end
  end

  assign cur_hit = cur_alive
                 && in_span(cur_x, aim_x_q, HIT_W)
                 && in_span(cur_y, aim_y_q, HIT_H);

  // Scan FSM: next state, datapath updates and registered-output next values
  always_comb begin
    state_d      = state_q;
    aim_x_d      = aim_x_q;
    aim_y_d      = aim_y_q;
    idx_d        = idx_q;
    kill_valid_d = kill_valid_q;
    kill_idx_d   = kill_idx_q;
    shot_miss_d  = 1'b0;
    cnt_d        = cnt_q;
    score_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fire_edge) begin
          aim_x_d = aim_x;
          aim_y_d = aim_y;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (cur_hit) begin
          kill_idx_d   = idx_q;
          kill_valid_d = 1'b1;
          state_d      = ST_KILL;
        end else if (idx_q == LAST_IDX) begin
          shot_miss_d = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = ST_COOLDOWN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_KILL: begin
        if (kill_ready) begin
          kill_valid_d = 1'b0;
          score_inc    = 1'b1;
          cnt_d        = CNT_LOAD;
          state_d      = ST_COOLDOWN;
        end
      end

      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; the edge register tracks fire in every state
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fire_prev_q  <= 1'b0;
      aim_x_q      <= '0;
      aim_y_q      <= '0;
      idx_q        <= '0;
      kill_valid_q <= 1'b0;
      kill_idx_q   <= '0;
      shot_miss_q  <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      fire_prev_q  <= fire;
      aim_x_q      <= aim_x_d;
      aim_y_q      <= aim_y_d;
      idx_q        <= idx_d;
      kill_valid_q <= kill_valid_d;
      kill_idx_q   <= kill_idx_d;
      shot_miss_q  <= shot_miss_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  bcd_score_counter u_score (
    .clk_i       (clk25),
    .rst_i       (reset),
    .inc_i       (score_inc),
    .score_bcd_o (score_bcd)
  );

  assign kill_valid = kill_valid_q;
  assign kill_idx   = kill_idx_q;
  assign shot_miss  = shot_miss_q;
  assign busy       = busy_q;

endmodule

// File: doc/mosquito_hit_detector.md
# mosquito_hit_detector

Consumes the mosquito position/alive state produced by the motion controller and checks it against the player's aim point when the fire button is pressed. It scans all mosquitoes sequentially and issues one kill request back to the motion controller over a valid/ready handshake. It keeps a two-digit BCD score and enforces a cooldown between shots. It sits between the input synchroniser (fire, aim) and the motion controller / 7-segment score display.

## Interface

- `N_MOSQ`, 2: number of mosquitoes scanned (1–8).
- `MOSQ_W`, 32: hitbox width in pixels.
- `MOSQ_H`, 32: hitbox height in pixels.
- `COOLDOWN_CYCLES`, 12_500_000: idle cycles after each shot (0.5 s at 25 MHz); must be ≥ 1.
- `clk25` in 1: 25 MHz pixel/system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `fire` in 1: fire button level, already synchronised to `clk25`.
- `aim_x` in 10: aim point x, 0–639.
- `aim_y` in 10: aim point y, 0–479.
- `mosq_x` in 10·N_MOSQ: packed x positions; index i occupies bits [10i+9:10i].
- `mosq_y` in 10·N_MOSQ: packed y positions, same packing.
- `mosq_alive` in N_MOSQ: per-mosquito alive flags.
- `kill_valid` out 1: kill request pending.
- `kill_idx` out 3: index of the mosquito to kill; valid while `kill_valid` is high.
- `kill_ready` in 1: motion controller accepts the kill.
- `shot_miss` out 1: one-cycle pulse when a shot hits nothing.
- `busy` out 1: high in every state except IDLE.
- `score_bcd` out 8: score as two BCD digits {tens, ones}.

## Operation

- **Reset values:** all outputs 0, state IDLE, edge register `fire_d` = 0, cooldown counter = 0.
- **Edge detect:** a shot triggers on `fire & ~fire_d`. `fire_d` updates every cycle in every state, so a held button never retriggers. Edges seen outside IDLE are dropped, not queued.
- **IDLE:** on a fire edge, latch `aim_x`/`aim_y`, set `idx` = 0, go to SCAN.
- **SCAN:** evaluate one index per cycle.
  - Hit for index i = `mosq_alive[i]` and mx ≤ ax ≤ mx+MOSQ_W−1 and my ≤ ay ≤ my+MOSQ_H−1.
  - Bounds are computed in 11 bits, so mx+MOSQ_W never wraps.
  - Positions and alive flags are sampled live in the cycle that index is evaluated.
  - On the first hit: register `kill_idx` = i, set `kill_valid`, go to KILL. The lowest index wins; at most one kill per shot.
  - If `idx` = N_MOSQ−1 with no hit: pulse `shot_miss`, go to COOLDOWN.
- **KILL:** hold `kill_valid` and `kill_idx` stable until `kill_ready`. Then:
  - Drop `kill_valid`.
  - Increment the score.
  - Go to COOLDOWN.
  - No timeout; the request is held even if the mosquito dies meanwhile.
- **COOLDOWN:** load the counter with COOLDOWN_CYCLES−1 on entry, decrement each cycle, go to IDLE on the cycle after it reads 0.
- **Score:** BCD increment; ones digit 9 → 0 with a carry into tens. Saturates at 99, so further hits leave it at 99. Cleared only by `reset`.
- **Reset mid-operation:** any state returns to IDLE immediately; a pending kill is abandoned and `kill_valid` falls asynchronously.

## Timing

- Edge E0 samples `fire`=1 with `fire_d`=0; the state is SCAN after E0.
- Index i is compared at edge E(1+i).
- On a hit at index i, `kill_valid` is high after E(1+i). Best case is 2 edges from the button edge.
- A handshake completes at the edge where `kill_valid & kill_ready`. `score_bcd` updates at that same edge.
- If `kill_ready` is already high, `kill_valid` is high for exactly 1 cycle.
- On a miss, `shot_miss` is high for the one cycle following edge E(N_MOSQ).
- `busy` rises after E0 and falls after the edge on which the cooldown counter reads 0, i.e. COOLDOWN_CYCLES cycles after entering COOLDOWN.
- All outputs are registered; no combinational input-to-output paths.

## Structure

- Shared `mosquito_pkg`:
  - Constants: coordinate width (10), N_MOSQ, sprite W/H, screen 640×480.
  - State enum: IDLE, SCAN, KILL, COOLDOWN.
  - Also used by the motion controller and the renderer.
- One sub-module, `bcd_score_counter`: an `inc` strobe in, saturating two-digit BCD out, async reset.
- The scan FSM, edge detector and cooldown counter stay in the top level.

## Test plan

- **Hit index 1:** mosquito 0 at (200,0), mosquito 1 at (440,100), both alive, aim (450,110), one fire pulse, `kill_ready`=1 → `kill_valid` high 1 cycle after E2 with `kill_idx`=1; `score_bcd` 0x00 → 0x01; `busy` stays high for the cooldown.
- **Miss:** aim (0,479), same mosquitoes → `shot_miss` pulse after E2; no `kill_valid`; score unchanged.
- **Boundaries and overlap:**
  - Aim (231,31) on mosquito (200,0) → hit.
  - Aim (232,31) → miss.
  - Mosquito at (620,460) with aim (639,479) → hit (no wrap).
  - Both mosquitoes overlapping the aim → `kill_idx`=0.
  - Dead mosquito under the aim → miss.
- **Backpressure:** `kill_ready`=0 for 5 cycles after a hit → `kill_valid`/`kill_idx` stable for all 5 cycles; score increments only at the accepting edge.
- **Retrigger:** fire held high for 100 cycles, plus extra edges during SCAN/KILL/COOLDOWN with COOLDOWN_CYCLES=8 → exactly one shot. A new edge after `busy` falls produces a second shot.
- **Saturation and reset:**
  - 100 hits → score reads 0x99 and holds.
  - Assert `reset` in KILL while `kill_ready`=0 → `kill_valid`, `busy` and score go to 0 without waiting for a clock edge.
